nurse_call_ctrl: RTL and testbench

Parametrised nurse-call controller for N_BEDS bedside call buttons.
- Synchronises and edge-detects each button and latches each request until a nurse acknowledges it.
- Serves requests one at a time in fixed priority (lowest index first), blinking the LED of the bed being served.
- Escalates any call left unacknowledged too long.
- Sits between the raw button inputs and the ward LED panel and buzzer driver.

---
 rtl/nurse_call_ctrl.sv | 175 +++++++++++++++++
 tb/tb_nurse_call_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nurse_call_ctrl.sv
// Nurse-call controller: synchronises and edge-detects N_BEDS bedside buttons,
// latches each request until acknowledged, serves one bed at a time (lowest
// index first) with a blinking LED and buzzer, and escalates unanswered calls.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   call         raw bedside buttons (asynchronous, active-high)
//   ack          nurse acknowledge for the served bed (1-cycle pulse)
//   led          per-bed indicator (served bed blinks, other pending beds steady)
//   active_id    index of the bed being served
//   active_valid high while a bed is being served
//   buzzer       audible alert (blink phase in ALERT, steady in ESCALATE)
//   escalate     high while in ESCALATE
module nurse_call_ctrl #(
  parameter int unsigned N_BEDS     = 4,
  parameter int unsigned BLINK_HALF = 4,
  parameter int unsigned ESC_CYCLES = 32,
  localparam int unsigned ID_W      = (N_BEDS > 1) ? $clog2(N_BEDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BEDS-1:0] call,
  input  logic              ack,
  output logic [N_BEDS-1:0] led,
  output logic [ID_W-1:0]   active_id,
  output logic              active_valid,
  output logic              buzzer,
  output logic              escalate
);

  localparam int unsigned TMR_W = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ESC_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALERT = 2'd1,
    ST_ESC   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_BEDS-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_BEDS-1:0]  armed_q, armed_d;
  logic [1:0]         settle_q, settle_d;
  logic [N_BEDS-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [N_BEDS-1:0]  led_q, led_d;
  logic               active_valid_q, active_valid_d;
  logic               buzzer_q, buzzer_d;
  logic               escalate_q, escalate_d;

  logic               settled;
  logic [N_BEDS-1:0]  rise;
  logic [N_BEDS-1:0]  clr;
  logic [ID_W-1:0]    lowest;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      armed_q        <= '0;
      settle_q       <= '0;
      pending_q      <= '0;
      active_id_q    <= '0;
      timer_q        <= '0;
      blink_cnt_q    <= '0;
      phase_q        <= 1'b0;
      led_q          <= '0;
      active_valid_q <= 1'b0;
      buzzer_q       <= 1'b0;
      escalate_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      armed_q        <= armed_d;
      settle_q       <= settle_d;
      pending_q      <= pending_d;
      active_id_q    <= active_id_d;
      timer_q        <= timer_d;
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      led_q          <= led_d;
      active_valid_q <= active_valid_d;
      buzzer_q       <= buzzer_d;
      escalate_q     <= escalate_d;
    end
  end

  // Next-state, request latching, blink and output decode.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    timer_d     = timer_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    clr         = '0;
    lowest      = '0;

    s1_d = call;
    s2_d = s1_q;
    s3_d = s2_q;

    // A bed only arms once its synchronised button has been seen low after
    // the pipeline has refilled from reset, so a held button is not re-latched.
    settled  = (settle_q == 2'd2);
    settle_d = settled ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ({N_BEDS{settled}} & ~s2_q);
    rise     = s2_q & ~s3_q & armed_q;

    for (int i = N_BEDS - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = ID_W'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d     = ST_ALERT;
          active_id_d = lowest;
          timer_d     = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
        end
      end
      ST_ALERT, ST_ESC: begin
        if (blink_cnt_q == BLK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end
        if (ack) begin
          state_d = ST_IDLE;
          for (int i = 0; i < N_BEDS; i++) begin
            if (ID_W'(i) == active_id_q) clr[i] = 1'b1;
          end
        end else if (state_q == ST_ALERT) begin
          // Escalate before the timer would wrap; it then holds.
          if (timer_q == TMR_LAST) state_d = ST_ESC;
          else                     timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set wins over a same-edge clear.
    pending_d = (pending_q & ~clr) | rise;

    led_d = pending_d;
    if (state_d == ST_ALERT) begin
      for (int i = 0; i < N_BEDS; i++) begin
        if (ID_W'(i) == active_id_d) led_d[i] = phase_d;
      end
    end
    active_valid_d = (state_d != ST_IDLE);
    escalate_d     = (state_d == ST_ESC);
    buzzer_d       = (state_d == ST_ESC) | ((state_d == ST_ALERT) & phase_d);
  end

  assign led          = led_q;
  assign active_id    = active_id_q;
  assign active_valid = active_valid_q;
  assign buzzer       = buzzer_q;
  assign escalate     = escalate_q;

endmodule

// File: tb/tb_nurse_call_ctrl.sv
// Directed self-checking bench for nurse_call_ctrl with default parameters.
module tb_nurse_call_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] call;
  logic       ack;
  logic [3:0] led;
  logic [1:0] active_id;
  logic       active_valid;
  logic       buzzer;
  logic       escalate;

  int n_tests = 0;
  int n_fail  = 0;

  nurse_call_ctrl #(
    .N_BEDS    (4),
    .BLINK_HALF(4),
    .ESC_CYCLES(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call        (call),
    .ack         (ack),
    .led         (led),
    .active_id   (active_id),
    .active_valid(active_valid),
    .buzzer      (buzzer),
    .escalate    (escalate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    call  = 4'b0000;
    ack   = 1'b0;
    #12;
    check_eq("rst_led",   32'(led), 32'h0);
    check_eq("rst_valid", 32'(active_valid), 32'h0);
    check_eq("rst_id",    32'(active_id), 32'h0);
    check_eq("rst_buzz",  32'(buzzer), 32'h0);
    check_eq("rst_esc",   32'(escalate), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);

    // Single call on bed 2: pending after 3 edges, served on the 4th.
    call = 4'b0100;
    step(3);
    check_eq("single_pend_led",   32'(led), 32'h4);
    check_eq("single_pend_valid", 32'(active_valid), 32'h0);
    step(1);
    check_eq("single_valid", 32'(active_valid), 32'h1);
    check_eq("single_id",    32'(active_id), 32'h2);
    check_eq("single_led_on", 32'(led), 32'h4);
    check_eq("single_buzz_on", 32'(buzzer), 32'h1);
    step(3);
    check_eq("blink_a3_led", 32'(led), 32'h4);
    call = 4'b0000;
    step(1);
    check_eq("blink_a4_led",  32'(led), 32'h0);
    check_eq("blink_a4_buzz", 32'(buzzer), 32'h0);
    step(3);
    check_eq("blink_a7_led",  32'(led), 32'h0);
    step(1);
    check_eq("blink_a8_led",  32'(led), 32'h4);
    check_eq("blink_a8_buzz", 32'(buzzer), 32'h1);
    pulse_ack();
    check_eq("single_ack_valid", 32'(active_valid), 32'h0);
    check_eq("single_ack_led",   32'(led), 32'h0);
    check_eq("single_ack_buzz",  32'(buzzer), 32'h0);

    // Simultaneous calls on beds 1 and 3.
    call = 4'b1010;
    step(4);
    check_eq("sim_id",    32'(active_id), 32'h1);
    check_eq("sim_valid", 32'(active_valid), 32'h1);
    check_eq("sim_led",   32'(led), 32'ha);
    step(4);
    check_eq("sim_led_off", 32'(led), 32'h8);
    call = 4'b0000;
    pulse_ack();
    check_eq("sim_gap_valid", 32'(active_valid), 32'h0);
    check_eq("sim_gap_led",   32'(led), 32'h8);
    step(1);
    check_eq("sim_next_id",    32'(active_id), 32'h3);
    check_eq("sim_next_valid", 32'(active_valid), 32'h1);
    check_eq("sim_next_led",   32'(led), 32'h8);

    // No preemption: bed 0 rises while bed 3 is served.
    call = 4'b0001;
    step(3);
    check_eq("nopre_led_a3", 32'(led), 32'h9);
    check_eq("nopre_id",     32'(active_id), 32'h3);
    step(1);
    check_eq("nopre_led_a4", 32'(led), 32'h1);
    call = 4'b0000;
    pulse_ack();
    check_eq("nopre_gap_valid", 32'(active_valid), 32'h0);
    check_eq("nopre_gap_led",   32'(led), 32'h1);
    step(1);
    check_eq("nopre_next_id",    32'(active_id), 32'h0);
    check_eq("nopre_next_valid", 32'(active_valid), 32'h1);
    pulse_ack();
    check_eq("nopre_done_led", 32'(led), 32'h0);

    // Ack while idle is ignored.
    pulse_ack();
    step(2);
    check_eq("idle_ack_valid", 32'(active_valid), 32'h0);
    check_eq("idle_ack_led",   32'(led), 32'h0);

    // Escalation on bed 1, button held throughout.
    call = 4'b0010;
    step(4);
    check_eq("esc_entry_id",  32'(active_id), 32'h1);
    check_eq("esc_entry_esc", 32'(escalate), 32'h0);
    step(31);
    check_eq("esc_31_esc",   32'(escalate), 32'h0);
    check_eq("esc_31_valid", 32'(active_valid), 32'h1);
    step(1);
    check_eq("esc_32_esc",  32'(escalate), 32'h1);
    check_eq("esc_32_buzz", 32'(buzzer), 32'h1);
    check_eq("esc_32_led",  32'(led), 32'h2);
    step(5);
    check_eq("esc_37_buzz", 32'(buzzer), 32'h1);
    check_eq("esc_37_led",  32'(led), 32'h2);
    check_eq("esc_37_esc",  32'(escalate), 32'h1);
    pulse_ack();
    check_eq("esc_ack_esc",   32'(escalate), 32'h0);
    check_eq("esc_ack_led",   32'(led), 32'h0);
    check_eq("esc_ack_valid", 32'(active_valid), 32'h0);
    step(6);
    check_eq("held_valid", 32'(active_valid), 32'h0);
    check_eq("held_led",   32'(led), 32'h0);
    call = 4'b0000;

    // Ack on the same edge as timer expiry.
    call = 4'b0100;
    step(2);
    call = 4'b0000;
    step(2);
    check_eq("race_entry_valid", 32'(active_valid), 32'h1);
    check_eq("race_entry_id",    32'(active_id), 32'h2);
    step(31);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("race_esc",   32'(escalate), 32'h0);
    check_eq("race_valid", 32'(active_valid), 32'h0);
    check_eq("race_led",   32'(led), 32'h0);
    step(3);
    check_eq("race_esc_later", 32'(escalate), 32'h0);

    // Ack coinciding with a new rise on the same bed.
    call = 4'b0100;
    step(2);
    call = 4'b0000;
    step(2);
    check_eq("coin_entry_valid", 32'(active_valid), 32'h1);
    step(2);
    call = 4'b0100;
    step(2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("coin_gap_valid", 32'(active_valid), 32'h0);
    check_eq("coin_gap_led",   32'(led), 32'h4);
    step(1);
    check_eq("coin_reserve_valid", 32'(active_valid), 32'h1);
    check_eq("coin_reserve_id",    32'(active_id), 32'h2);
    call = 4'b0000;
    pulse_ack();
    check_eq("coin_done_led", 32'(led), 32'h0);

    // Async reset mid-ESCALATE with the button still held.
    call = 4'b1000;
    step(4);
    check_eq("ar_entry_id", 32'(active_id), 32'h3);
    step(32);
    check_eq("ar_esc", 32'(escalate), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_led",   32'(led), 32'h0);
    check_eq("ar_valid", 32'(active_valid), 32'h0);
    check_eq("ar_esc0",  32'(escalate), 32'h0);
    check_eq("ar_buzz",  32'(buzzer), 32'h0);
    check_eq("ar_id",    32'(active_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    check_eq("ar_held_valid", 32'(active_valid), 32'h0);
    check_eq("ar_held_led",   32'(led), 32'h0);
    call = 4'b0000;
    step(3);
    call = 4'b1000;
    step(4);
    check_eq("ar_repress_valid", 32'(active_valid), 32'h1);
    check_eq("ar_repress_id",    32'(active_id), 32'h3);
    check_eq("ar_repress_led",   32'(led), 32'h8);
    call = 4'b0000;
    pulse_ack();
    check_eq("ar_done_valid", 32'(active_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
